// File: rtl/led_matrix_scan.sv
// LED matrix scan controller for a 64x64 panel with 4-bit pixel intensity.
// Each row is shown in 15 binary-weighted-by-count subframes. For each
// subframe it shifts 64 column bits out serially, latches them, then holds
// the panel enabled for SHOW_CYCLES clocks.
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous reset, active-high
//   enable     scan-run request, sampled in IDLE and at the end of SHOW
//   ram_addr   frame-buffer read address {row, col}
//   ram_q      frame-buffer data, 2-cycle read latency
//   row_sel    panel row address, updated in the LATCH cycle
//   ser_data   column shift data
//   ser_clk    column shift clock, panel samples on rising edge
//   latch      column latch strobe
//   oe_n       panel output enable, active-low
//   frame_done one-cycle pulse after the last subframe of the frame
module led_matrix_scan #(
   parameter int unsigned SHOW_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [11:0] ram_addr,
   input  logic [3:0]  ram_q,
   output logic [5:0]  row_sel,
   output logic        ser_data,
   output logic        ser_clk,
   output logic        latch,
   output logic        oe_n,
   output logic        frame_done
);

   typedef enum logic [2:0] {
      StIdle,
      StPrime,
      StShift,
      StLatch,
      StShow
   } state_e;

   localparam logic [7:0] ShowLast  = 8'(SHOW_CYCLES - 1);
   localparam logic [7:0] PrimeLast = 8'd1;
   localparam logic [7:0] ShiftLast = 8'd127;

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic [5:0] row_q, row_d;
   logic [3:0] sub_q, sub_d;
   logic [5:0] row_sel_q, row_sel_d;
   logic       frame_done_q, frame_done_d;
   logic [5:0] col_ahead;

   // Two shift cycles per column; address runs one column ahead of the bit
   // period being shifted, which with the 2-cycle read latency lines the data
   // up with the period it belongs to. Column 0 is fetched during PRIME.
   assign col_ahead = cnt_q[6:1] + 6'd1;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + 8'd1;
      row_d        = row_q;
      sub_d        = sub_q;
      row_sel_d    = row_sel_q;
      frame_done_d = 1'b0;
      ram_addr     = {row_q, 6'd0};
      ser_data     = 1'b0;
      ser_clk      = 1'b0;
      latch        = 1'b0;
      oe_n         = 1'b1;

      unique case (state_q)
         StIdle: begin
            cnt_d = 8'd0;
            if (enable) begin
               state_d = StPrime;
            end
         end

         StPrime: begin
            if (cnt_q == PrimeLast) begin
               state_d = StShift;
               cnt_d   = 8'd0;
            end
         end

         StShift: begin
            ram_addr = {row_q, col_ahead};
            ser_clk  = cnt_q[0];
            ser_data = (ram_q > sub_q);
            if (cnt_q == ShiftLast) begin
               state_d   = StLatch;
               cnt_d     = 8'd0;
               // Loaded on entry so row_sel already shows the row during LATCH.
               row_sel_d = row_q;
            end
         end

         StLatch: begin
            latch   = 1'b1;
            state_d = StShow;
            cnt_d   = 8'd0;
         end

         StShow: begin
            oe_n = 1'b0;
            if (cnt_q == ShowLast) begin
               cnt_d   = 8'd0;
               state_d = enable ? StPrime : StIdle;
               if (sub_q != 4'd14) begin
                  sub_d = sub_q + 4'd1;
               end else begin
                  sub_d = 4'd0;
                  if (row_q != 6'd63) begin
                     row_d = row_q + 6'd1;
                  end else begin
                     row_d        = 6'd0;
                     frame_done_d = 1'b1;
                  end
               end
            end
         end

         default: begin
            state_d = StIdle;
            cnt_d   = 8'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= 8'd0;
         row_q        <= 6'd0;
         sub_q        <= 4'd0;
         row_sel_q    <= 6'd0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         row_q        <= row_d;
         sub_q        <= sub_d;
         row_sel_q    <= row_sel_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign row_sel    = row_sel_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scan.sv
// Directed bench for led_matrix_scan: walks the scan subframe by subframe
// with a fixed cycle schedule and compares every observable against a
// frame-buffer model and hand-computed counts.
module tb_led_matrix_scan;

   localparam int unsigned Show   = 32;
   localparam int          SubLen = 131 + Show;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [11:0] ram_addr;
   logic [3:0]  ram_q = 4'd0;
   logic [3:0]  q1 = 4'd0;
   logic [5:0]  row_sel;
   logic        ser_data;
   logic        ser_clk;
   logic        latch;
   logic        oe_n;
   logic        frame_done;

   logic [3:0]  mem [0:4095];
   int          cyc = 0;
   int          fd_cyc = -1;
   int          sf_start = 0;
   int          n_vec = 0;
   int          n_bad = 0;

   led_matrix_scan #(.SHOW_CYCLES(Show)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .ram_addr   (ram_addr),
      .ram_q      (ram_q),
      .row_sel    (row_sel),
      .ser_data   (ser_data),
      .ser_clk    (ser_clk),
      .latch      (latch),
      .oe_n       (oe_n),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // Frame buffer with 2-cycle read latency.
   always @(posedge clk) begin
      q1    <= mem[ram_addr];
      ram_q <= q1;
      cyc   <= cyc + 1;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Follows one subframe starting at its first PRIME cycle. drop_at clears
   // enable at that offset; abort_at raises reset at that offset and returns.
   task automatic run_subframe(input int row, input int sub, input int drop_at,
                               input int abort_at, input int exp_fd, output int ones);
      int   rises = 0, first_rise = -1, data_bad = 0, quiet_bad = 0, clk_bad = 0;
      int   oe_low = 0, oe_bad = 0, latch_n = 0, latch_at = -1, rsel = -1;
      int   prime_bad = 0, fd_n = 0, exp_ones = 0;
      logic prev_clk = 1'b0;
      logic exp_bit;
      string t;
      ones = 0;
      for (int c = 0; c < 64; c++) begin
         if (mem[row*64 + c] > 4'(sub)) exp_ones++;
      end
      for (int k = 0; k < SubLen; k++) begin
         @(negedge clk);
         if (k == 0) sf_start = cyc;
         if (frame_done) begin
            fd_n++;
            fd_cyc = cyc;
         end
         if (k < 2 && ram_addr !== 12'(row*64)) prime_bad++;
         if (k >= 2 && k < 130) begin
            exp_bit = (mem[row*64 + (k-2)/2] > 4'(sub));
            if (ser_data !== exp_bit) data_bad++;
            if (ser_clk !== ((k % 2) == 1)) clk_bad++;
            if (ser_clk && !prev_clk) begin
               rises++;
               if (first_rise < 0) first_rise = k;
               if (ser_data) ones++;
            end
         end else if (ser_data !== 1'b0 || ser_clk !== 1'b0) begin
            quiet_bad++;
         end
         if (latch) begin
            latch_n++;
            latch_at = k;
            rsel     = int'(row_sel);
         end
         if (!oe_n) begin
            oe_low++;
            if (k < 131) oe_bad++;
         end
         prev_clk = ser_clk;
         if (k == drop_at) enable = 1'b0;
         if (k == abort_at) begin
            reset = 1'b1;
            break;
         end
      end
      t = $sformatf("r%0d s%0d", row, sub);
      check_eq({t, " frame_done"}, fd_n, exp_fd);
      check_eq({t, " data"}, data_bad, 0);
      check_eq({t, " idle_lines"}, quiet_bad, 0);
      check_eq({t, " prime_addr"}, prime_bad, 0);
      if (abort_at < 0) begin
         check_eq({t, " rises"}, rises, 64);
         check_eq({t, " first_rise"}, first_rise, 3);
         check_eq({t, " ser_clk"}, clk_bad, 0);
         check_eq({t, " ones"}, ones, exp_ones);
         check_eq({t, " latch_n"}, latch_n, 1);
         check_eq({t, " latch_at"}, latch_at, 130);
         check_eq({t, " row_sel"}, rsel, row);
         check_eq({t, " oe_low"}, oe_low, int'(Show));
         check_eq({t, " oe_early"}, oe_bad, 0);
      end else begin
         check_eq({t, " abort_latch"}, latch_n, 1);
      end
   endtask

   initial begin
      int ones, bad, t0, v;
      reset  = 1'b1;
      enable = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 4'hF;
      repeat (3) @(negedge clk);
      check_eq("rst oe_n", int'(oe_n), 1);
      check_eq("rst ser_clk", int'(ser_clk), 0);
      check_eq("rst latch", int'(latch), 0);
      check_eq("rst ser_data", int'(ser_data), 0);
      check_eq("rst frame_done", int'(frame_done), 0);
      check_eq("rst ram_addr", int'(ram_addr), 0);
      check_eq("rst row_sel", int'(row_sel), 0);

      // Reset wins over enable.
      enable = 1'b1;
      @(negedge clk);
      check_eq("rst_prio oe_n", int'(oe_n), 1);
      check_eq("rst_prio ser_clk", int'(ser_clk), 0);
      reset = 1'b0;

      // All 4'hF: every column lit in subframe 0.
      run_subframe(0, 0, -1, -1, 0, ones);
      check_eq("allF ones", ones, 64);

      for (int r = 0; r < 64; r++) begin
         for (int c = 0; c < 64; c++) begin
            case (r)
               0:       v = 15 - (c % 16);
               2:       v = c / 4;
               5:       v = c % 16;
               62:      v = (c < 32) ? 15 : 0;
               63:      v = (c % 2 == 1) ? 15 : 0;
               default: v = 0;
            endcase
            mem[r*64 + c] = 4'(v);
         end
      end

      // Frame A: enable drop at row 2 sub 3, reset during SHOW of row 63 sub 14.
      for (int r = 0; r < 64; r++) begin
         for (int s = 0; s < 15; s++) begin
            if (r == 0 && s == 0) continue;
            if (r == 2 && s == 3) begin
               run_subframe(r, s, 40, -1, 0, ones);
               bad = 0;
               repeat (6) begin
                  @(negedge clk);
                  if (oe_n !== 1'b1 || ser_clk !== 1'b0 || latch !== 1'b0 ||
                      ser_data !== 1'b0) bad++;
               end
               check_eq("idle after drop", bad, 0);
               enable = 1'b1;
            end else if (r == 63 && s == 14) begin
               run_subframe(r, s, -1, 140, 0, ones);
               @(negedge clk);
               check_eq("abort oe_n", int'(oe_n), 1);
               check_eq("abort row_sel", int'(row_sel), 0);
               check_eq("abort latch", int'(latch), 0);
               bad = 0;
               repeat (3) begin
                  if (frame_done !== 1'b0) bad++;
                  @(negedge clk);
               end
               check_eq("abort frame_done", bad, 0);
               reset = 1'b0;
            end else begin
               run_subframe(r, s, -1, -1, 0, ones);
               if (r == 2 && s == 4) check_eq("resume r2 s4 ones", ones, 44);
               if (r == 5 && s == 7) check_eq("row5 s7 ones", ones, 32);
            end
         end
      end

      // Frame B: clean frame from row 0 sub 0, across the 63 -> 0 wrap.
      t0 = 0;
      for (int r = 0; r < 64; r++) begin
         for (int s = 0; s < 15; s++) begin
            run_subframe(r, s, -1, -1, 0, ones);
            if (r == 0 && s == 0) begin
               t0 = sf_start;
               check_eq("restart r0 s0 ones", ones, 60);
            end
            if (r == 62 && s == 9) check_eq("row62 ones", ones, 32);
            if (r == 63 && s == 9) check_eq("row63 ones", ones, 32);
         end
      end
      run_subframe(0, 0, -1, -1, 1, ones);
      check_eq("wrap r0 s0 ones", ones, 60);
      check_eq("frame length", fd_cyc - t0, 960 * SubLen);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
